lif_fire_layer3: RTL and testbench
==================================

LIF_FIRE_LAYER3 -- requirements
Module: lif_fire_layer3

Interface
REQ-001 SHALL have parameter BIT_WIDTH_BIG_MEMBRANE, default 16, stored membrane width.
REQ-002 SHALL have parameter NUM_NEURON, default 10, number of layer-3 neurons; address width ADDR_W = clog2(NUM_NEURON).
REQ-003 SHALL have parameter THRESHOLD, default 16'sd256, signed firing threshold.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 upd_valid_i  input  1  membrane_update_i is valid this cycle.
REQ-007 upd_addr_i  input  ADDR_W  neuron index of the update.
REQ-008 membrane_update_i  input  BIT_WIDTH_BIG_MEMBRANE  signed saturated sum from the upstream adder.
REQ-009 rd_addr_i  input  ADDR_W  neuron index read back to the adder.
REQ-010 membrane_o  output  BIT_WIDTH_BIG_MEMBRANE  combinational read of entry rd_addr_i.
REQ-011 timestep_end_i  input  1  one-cycle pulse ending the timestep.
REQ-012 busy_o  output  1  high while the block is not in ACCUM.
REQ-013 spike_valid_o  output  1  spike_addr_o is offered downstream.
REQ-014 spike_ready_i  input  1  downstream accepts the spike.
REQ-015 spike_addr_o  output  ADDR_W  index of the firing neuron.
REQ-016 done_o  output  1  one-cycle pulse after the scan completes.

Function
REQ-017 FSM states SHALL be ACCUM, SCAN, SPIKE and DONE.
REQ-018 ACCUM: upd_valid_i SHALL write membrane_update_i into entry upd_addr_i at the next edge; upd_addr_i >= NUM_NEURON SHALL be ignored.
REQ-019 ACCUM plus timestep_end_i SHALL go to SCAN with scan index 0; an update in that same cycle SHALL still be written.
REQ-020 Updates arriving outside ACCUM SHALL be dropped; upstream SHALL gate on busy_o.
REQ-021 SCAN SHALL evaluate one neuron per cycle; fire when membrane >= THRESHOLD (signed compare).
REQ-022 Non-firing neuron: index SHALL increment; after index NUM_NEURON-1 the FSM SHALL go to DONE.
REQ-023 Firing neuron: FSM SHALL go to SPIKE, assert spike_valid_o with spike_addr_o = index, and apply the reset rule to that entry.
REQ-024 SPIKE SHALL hold spike_valid_o and spike_addr_o stable until spike_valid_o && spike_ready_i, then resume SCAN at index+1, or go to DONE if index was NUM_NEURON-1.
REQ-025 DONE SHALL pulse done_o for exactly one cycle and return to ACCUM.
REQ-026 Latency SHALL be NUM_NEURON + 1 + (number of spikes) + (stall cycles) from timestep_end_i to done_o.
REQ-027 timestep_end_i outside ACCUM SHALL be ignored.
REQ-028 The membrane read SHALL return stored contents; there is no write-to-read bypass.

Reset
REQ-029 Reset SHALL force ACCUM, scan index 0, all membrane entries 0, and spike_valid_o, done_o and busy_o to 0.
REQ-030 Reset during SCAN or SPIKE SHALL abort immediately; the pending spike SHALL be lost.

Configuration
REQ-031 Macro LAYER3_SOFT_RESET_EN defined: a firing neuron's entry SHALL become membrane - THRESHOLD, saturated to the signed range.
REQ-032 Macro LAYER3_SOFT_RESET_EN undefined: a firing neuron's entry SHALL become 0 (hard reset).

Structure
REQ-033 Package layer3_pkg SHALL hold the width constants, NUM_NEURON, THRESHOLD and the FSM state enum.
REQ-034 Threshold compare and reset arithmetic SHALL live in one sub-module, fire_compare_layer3 (inputs: membrane; outputs: fire, next membrane).

Verification
REQ-035 Write 300 to neuron 2 and 100 to all others, then pulse timestep_end_i with ready held high -> one spike with addr 2; entry 2 reads 44 (soft) or 0 (hard); done_o pulses 12 cycles after timestep_end_i.
REQ-036 Neurons 0 and 9 at 256, ready low for 5 cycles -> spike_addr_o holds at 0 for 5 cycles; then addr 9; done_o follows.
REQ-037 All entries at -32768 -> no spikes; done_o pulses 11 cycles after timestep_end_i; entries unchanged.
REQ-038 Update to addr 4 in the same cycle as timestep_end_i with value 500 -> neuron 4 fires.
REQ-039 Update sent while busy_o=1 -> entry unchanged; upd_addr_i=12 in ACCUM -> no entry changes.
REQ-040 Assert reset while in SPIKE -> spike_valid_o falls asynchronously; all entries read 0; FSM is in ACCUM.

Source files
------------

// File: rtl/layer3_pkg.sv
// Shared constants and FSM state type for the layer-3 LIF fire block.
package layer3_pkg;

    localparam int LAYER3_MEM_W      = 16;
    localparam int LAYER3_NUM_NEURON = 10;
    localparam logic signed [LAYER3_MEM_W-1:0] LAYER3_THRESHOLD = 16'sd256;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        SPIKE = 2'd2,
        DONE  = 2'd3
    } l3_state_e;

endpackage

// File: rtl/fire_compare_layer3.sv
// Threshold compare and post-fire membrane value for one neuron.
// LAYER3_SOFT_RESET_EN selects subtract-threshold (soft) instead of clear-to-zero (hard).
module fire_compare_layer3
    import layer3_pkg::*;
#(
    parameter int BIT_WIDTH_BIG_MEMBRANE = LAYER3_MEM_W,
    parameter logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] THRESHOLD = LAYER3_THRESHOLD
) (
    input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] membrane_i,
    output logic                                     fire_o,
    output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] membrane_next_o
);

    localparam int W = BIT_WIDTH_BIG_MEMBRANE;

`ifdef LAYER3_SOFT_RESET_EN
    // One guard bit catches overflow when THRESHOLD is negative.
    function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] diff;
        diff = {a[W-1], a} - {b[W-1], b};
        if (diff[W] != diff[W-1]) begin
            return diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return diff[W-1:0];
    endfunction
`endif

    always_comb begin
        fire_o = (membrane_i >= THRESHOLD);
`ifdef LAYER3_SOFT_RESET_EN
        membrane_next_o = sat_sub(membrane_i, THRESHOLD);
`else
        membrane_next_o = '0;
`endif
    end

endmodule

// File: rtl/lif_fire_layer3.sv
// Layer-3 LIF membrane store: accumulate updates, then scan for threshold crossings
// and emit spikes with ready/valid handshake. Optional macro: LAYER3_SOFT_RESET_EN.
module lif_fire_layer3
    import layer3_pkg::*;
#(
    parameter int BIT_WIDTH_BIG_MEMBRANE = LAYER3_MEM_W,
    parameter int NUM_NEURON = LAYER3_NUM_NEURON,
    parameter logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] THRESHOLD = LAYER3_THRESHOLD,
    localparam int ADDR_W = $clog2(NUM_NEURON)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     upd_valid_i,
    input  logic [ADDR_W-1:0]                        upd_addr_i,
    input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] membrane_update_i,
    input  logic [ADDR_W-1:0]                        rd_addr_i,
    output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] membrane_o,
    input  logic                                     timestep_end_i,
    output logic                                     busy_o,
    output logic                                     spike_valid_o,
    input  logic                                     spike_ready_i,
    output logic [ADDR_W-1:0]                        spike_addr_o,
    output logic                                     done_o
);

    localparam int W = BIT_WIDTH_BIG_MEMBRANE;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURON - 1);

    l3_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic signed [W-1:0]  mem_q [NUM_NEURON];

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic signed [W-1:0]  wr_data;
    logic                 fire;
    logic signed [W-1:0]  next_mem;

    fire_compare_layer3 #(
        .BIT_WIDTH_BIG_MEMBRANE(W),
        .THRESHOLD             (THRESHOLD)
    ) u_cmp (
        .membrane_i     (mem_q[idx_q]),
        .fire_o         (fire),
        .membrane_next_o(next_mem)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_addr = upd_addr_i;
        wr_data = membrane_update_i;
        case (state_q)
            ACCUM: begin
                wr_en = upd_valid_i && (upd_addr_i <= LAST_IDX);
                if (timestep_end_i) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (fire) begin
                    // Post-fire value is committed now so the spike can stall freely.
                    state_d = SPIKE;
                    wr_en   = 1'b1;
                    wr_addr = idx_q;
                    wr_data = next_mem;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            SPIKE: begin
                if (spike_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
            default: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURON; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign membrane_o    = (rd_addr_i <= LAST_IDX) ? mem_q[rd_addr_i] : '0;
    assign busy_o        = (state_q != ACCUM);
    assign spike_valid_o = (state_q == SPIKE);
    assign spike_addr_o  = idx_q;
    assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_lif_fire_layer3.sv
// Self-checking bench for lif_fire_layer3; spike addresses checked against a scoreboard queue.
module tb_lif_fire_layer3;

    logic               clk;
    logic               reset;
    logic               upd_valid_i;
    logic [3:0]         upd_addr_i;
    logic signed [15:0] membrane_update_i;
    logic [3:0]         rd_addr_i;
    logic signed [15:0] membrane_o;
    logic               timestep_end_i;
    logic               busy_o;
    logic               spike_valid_o;
    logic               spike_ready_i;
    logic [3:0]         spike_addr_o;
    logic               done_o;

    int checks;
    int failures;
    int exp_q[$];
    int obs_q[$];
    int hold_q[$];

`ifdef LAYER3_SOFT_RESET_EN
    localparam logic signed [15:0] EXP_N2_AFTER = 16'sd44;
    localparam logic signed [15:0] EXP_N4_AFTER = 16'sd244;
`else
    localparam logic signed [15:0] EXP_N2_AFTER = 16'sd0;
    localparam logic signed [15:0] EXP_N4_AFTER = 16'sd0;
`endif

    lif_fire_layer3 dut (
        .clk              (clk),
        .reset            (reset),
        .upd_valid_i      (upd_valid_i),
        .upd_addr_i       (upd_addr_i),
        .membrane_update_i(membrane_update_i),
        .rd_addr_i        (rd_addr_i),
        .membrane_o       (membrane_o),
        .timestep_end_i   (timestep_end_i),
        .busy_o           (busy_o),
        .spike_valid_o    (spike_valid_o),
        .spike_ready_i    (spike_ready_i),
        .spike_addr_o     (spike_addr_o),
        .done_o           (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_mem(input int a, input int v);
        upd_valid_i       = 1'b1;
        upd_addr_i        = 4'(a);
        membrane_update_i = 16'(v);
        @(posedge clk); #1;
        upd_valid_i = 1'b0;
    endtask

    task automatic resync();
        @(posedge clk); #1;
    endtask

    // Pulses timestep_end_i and runs until done_o; lat counts edges from the sampling edge.
    task automatic run_timestep(input int stall, input bit do_upd, input int ua, input int uv,
                                output int lat);
        int stall_left;
        stall_left = stall;
        obs_q.delete();
        hold_q.delete();
        timestep_end_i = 1'b1;
        if (do_upd) begin
            upd_valid_i       = 1'b1;
            upd_addr_i        = 4'(ua);
            membrane_update_i = 16'(uv);
        end
        spike_ready_i = (stall == 0);
        @(posedge clk); #1;
        timestep_end_i = 1'b0;
        upd_valid_i    = 1'b0;
        lat = 1;
        while (!done_o && lat <= 200) begin
            if (spike_valid_o) begin
                if (stall_left > 0) begin
                    spike_ready_i = 1'b0;
                    hold_q.push_back(int'(spike_addr_o));
                    stall_left--;
                end else begin
                    spike_ready_i = 1'b1;
                    obs_q.push_back(int'(spike_addr_o));
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!done_o) lat = -1;
        spike_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (busy_o !== 1'b0 || spike_valid_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b spike_valid=%b done=%b, required 0 0 0",
                     busy_o, spike_valid_o, done_o);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr_i = 4'(i);
            #1;
            checks++;
            if (membrane_o !== 16'sd0) begin
                failures++;
                $display("FAIL reset_entry%0d: got %0d, required 0", i, membrane_o);
            end
        end
    endtask

    task automatic test_single_spike();
        int lat;
        int e;
        int o;
        // Read of the entry being written must show old contents until the edge.
        rd_addr_i         = 4'd2;
        upd_valid_i       = 1'b1;
        upd_addr_i        = 4'd2;
        membrane_update_i = 16'sd300;
        #1;
        checks++;
        if (membrane_o !== 16'sd0) begin
            failures++;
            $display("FAIL no_bypass: got %0d, required 0", membrane_o);
        end
        @(posedge clk); #1;
        upd_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) if (i != 2) write_mem(i, 100);
        exp_q.push_back(2);
        run_timestep(0, 1'b0, 0, 0, lat);
        checks++;
        if (lat !== 12) begin
            failures++;
            $display("FAIL single_latency: got %0d, required 12", lat);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL single_count: got %0d spikes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_addr: got %0d, required %0d", o, e);
            end
        end
        resync();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b busy=%b, required 0 0", done_o, busy_o);
        end
        rd_addr_i = 4'd2;
        #1;
        checks++;
        if (membrane_o !== EXP_N2_AFTER) begin
            failures++;
            $display("FAIL single_entry2: got %0d, required %0d", membrane_o, EXP_N2_AFTER);
        end
        rd_addr_i = 4'd3;
        #1;
        checks++;
        if (membrane_o !== 16'sd100) begin
            failures++;
            $display("FAIL single_entry3: got %0d, required 100", membrane_o);
        end
        resync();
    endtask

    task automatic test_stall();
        int lat;
        int e;
        int o;
        for (int i = 0; i < 10; i++) write_mem(i, (i == 0 || i == 9) ? 256 : 0);
        exp_q.push_back(0);
        exp_q.push_back(9);
        run_timestep(5, 1'b0, 0, 0, lat);
        checks++;
        if (hold_q.size() !== 5) begin
            failures++;
            $display("FAIL stall_hold_cycles: got %0d, required 5", hold_q.size());
        end
        foreach (hold_q[i]) begin
            checks++;
            if (hold_q[i] !== 0) begin
                failures++;
                $display("FAIL stall_hold_addr: cycle %0d got %0d, required 0", i, hold_q[i]);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL stall_count: got %0d spikes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall_addr: got %0d, required %0d", o, e);
            end
        end
        checks++;
        if (lat !== 18) begin
            failures++;
            $display("FAIL stall_latency: got %0d, required 18", lat);
        end
        resync();
    endtask

    task automatic test_no_spike();
        int lat;
        for (int i = 0; i < 10; i++) write_mem(i, -32768);
        run_timestep(0, 1'b0, 0, 0, lat);
        checks++;
        if (lat !== 11 || obs_q.size() !== 0) begin
            failures++;
            $display("FAIL nospike_run: latency %0d spikes %0d, required 11 0", lat, obs_q.size());
        end
        resync();
        for (int i = 0; i < 10; i++) begin
            rd_addr_i = 4'(i);
            #1;
            checks++;
            if (membrane_o !== -16'sd32768) begin
                failures++;
                $display("FAIL nospike_entry%0d: got %0d, required -32768", i, membrane_o);
            end
        end
        resync();
    endtask

    task automatic test_same_cycle_update();
        int lat;
        int e;
        int o;
        for (int i = 0; i < 10; i++) write_mem(i, 0);
        exp_q.push_back(4);
        run_timestep(0, 1'b1, 4, 500, lat);
        checks++;
        if (obs_q.size() !== 1) begin
            failures++;
            $display("FAIL samecycle_count: got %0d spikes, required 1", obs_q.size());
        end
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL samecycle_addr: got %0d, required %0d", o, e);
        end
        resync();
        rd_addr_i = 4'd4;
        #1;
        checks++;
        if (membrane_o !== EXP_N4_AFTER) begin
            failures++;
            $display("FAIL samecycle_entry4: got %0d, required %0d", membrane_o, EXP_N4_AFTER);
        end
        resync();
    endtask

    task automatic test_busy_drop();
        int n;
        for (int i = 0; i < 10; i++) write_mem(i, 0);
        timestep_end_i = 1'b1;
        @(posedge clk); #1;
        timestep_end_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_high: got %b, required 1", busy_o);
        end
        write_mem(3, 999);
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy_o, n);
        end
        write_mem(12, 777);
        for (int i = 0; i < 10; i++) begin
            rd_addr_i = 4'(i);
            #1;
            checks++;
            if (membrane_o !== 16'sd0) begin
                failures++;
                $display("FAIL dropped_update_entry%0d: got %0d, required 0", i, membrane_o);
            end
        end
        resync();
    endtask

    task automatic test_reset_in_spike();
        int n;
        write_mem(0, 300);
        write_mem(6, 50);
        spike_ready_i  = 1'b0;
        timestep_end_i = 1'b1;
        @(posedge clk); #1;
        timestep_end_i = 1'b0;
        n = 0;
        while (!spike_valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (spike_valid_o !== 1'b1 || spike_addr_o !== 4'd0) begin
            failures++;
            $display("FAIL pre_reset_spike: valid=%b addr=%0d, required 1 0", spike_valid_o, spike_addr_o);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (spike_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b, required 0 0 0",
                     spike_valid_o, busy_o, done_o);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr_i = 4'(i);
            #0.5;
            checks++;
            if (membrane_o !== 16'sd0) begin
                failures++;
                $display("FAIL reset_clear_entry%0d: got %0d, required 0", i, membrane_o);
            end
        end
        spike_ready_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        write_mem(5, 123);
        rd_addr_i = 4'd5;
        #1;
        checks++;
        if (membrane_o !== 16'sd123 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_accum: entry5=%0d busy=%b, required 123 0", membrane_o, busy_o);
        end
        resync();
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        upd_valid_i       = 1'b0;
        upd_addr_i        = '0;
        membrane_update_i = '0;
        rd_addr_i         = '0;
        timestep_end_i    = 1'b0;
        spike_ready_i     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resync();
        reset = 1'b0;
        resync();
        test_single_spike();
        test_stall();
        test_no_spike();
        test_same_cycle_update();
        test_busy_drop();
        test_reset_in_spike();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
